// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: streams W0..W63 of one 512-bit block
// from a 16-word sliding window, one word per accepted advance.
module sha256_msg_schedule (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [511:0] block,
   input  logic         advance,
   output logic         w_valid,
   output logic [31:0]  w,
   output logic [5:0]   t,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [31:0] win_r [16];
   logic [31:0] w_r;
   logic [5:0]  t_r;
   logic [31:0] next_word_s;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'd0, x[31:3]};
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   // W_{t+16} from the current window; 32-bit sum wraps modulo 2^32.
   always_comb begin
      next_word_s = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
   end

   // State machine, window shift and registered w/t outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
         w_r     <= 32'd0;
         t_r     <= 6'd0;
         for (int i = 0; i < 16; i++) win_r[i] <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 16; i++) win_r[i] <= block[511 - 32*i -: 32];
                  w_r     <= block[511:480];
                  t_r     <= 6'd0;
                  state_r <= RUN;
               end else begin
                  w_r <= 32'd0;
                  t_r <= 6'd0;
               end
            end
            RUN: begin
               if (advance) begin
                  if (t_r == 6'd63) begin
                     // last word consumed: window is left as-is
                     state_r <= DONE;
                     w_r     <= 32'd0;
                     t_r     <= 6'd0;
                  end else begin
                     for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
                     win_r[15] <= next_word_s;
                     w_r       <= win_r[1];
                     t_r       <= t_r + 6'd1;
                  end
               end else begin
                  w_r <= w_r;
                  t_r <= t_r;
               end
            end
            DONE: begin
               state_r <= IDLE;
               w_r     <= 32'd0;
               t_r     <= 6'd0;
            end
            default: begin
               state_r <= IDLE;
               w_r     <= 32'd0;
               t_r     <= 6'd0;
            end
         endcase
      end
   end

   assign w       = w_r;
   assign t       = t_r;
   assign w_valid = (state_r == RUN);
   assign busy    = (state_r != IDLE);
   assign done    = (state_r == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: reference schedule model feeds
// a scoreboard queue that is popped as each word is accepted.
module tb_sha256_msg_schedule;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [511:0] block = 512'd0;
   logic         advance = 1'b0;
   logic         w_valid;
   logic [31:0]  w;
   logic [5:0]   t;
   logic         busy;
   logic         done;

   int checks = 0;
   int passes = 0;

   logic [31:0] exp_w [$];
   logic [5:0]  exp_t [$];

   logic [511:0] abc_blk;

   sha256_msg_schedule dut (
      .clk(clk), .reset_n(reset_n), .start(start), .block(block), .advance(advance),
      .w_valid(w_valid), .w(w), .t(t), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic void push_block(input logic [511:0] b);
      logic [31:0] m [64];
      for (int i = 0; i < 16; i++) m[i] = b[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) m[i] = ssig1(m[i-2]) + m[i-7] + ssig0(m[i-15]) + m[i-16];
      for (int i = 0; i < 64; i++) begin
         exp_w.push_back(m[i]);
         exp_t.push_back(i[5:0]);
      end
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0; start = 1'b1; block = abc_blk;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({w_valid, busy, done} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {w_valid, busy, done});
      else passes++;
      checks++;
      if (w !== 32'd0 || t !== 6'd0) $display("FAIL reset_wt got w=%h t=%0d exp w=0 t=0", w, t);
      else passes++;
      start = 1'b0; reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({w_valid, busy, done} !== 3'b000 || w !== 32'd0) $display("FAIL idle_after_reset got flags=%b w=%h exp 000/0", {w_valid, busy, done}, w);
      else passes++;
   endtask

   task automatic test_abc();
      int cyc = 0, first_v = -1, done_at = -1, nwords = 0;
      exp_w.delete(); exp_t.delete();
      block = abc_blk; start = 1'b1; advance = 1'b1; push_block(abc_blk);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 100 && done_at < 0) begin
         if (w_valid) begin
            if (first_v < 0) first_v = cyc;
            checks++;
            if (exp_w.size() == 0) $display("FAIL abc_extra got t=%0d w=%h exp no word", t, w);
            else if (w !== exp_w[0] || t !== exp_t[0]) $display("FAIL abc_word got t=%0d w=%h exp t=%0d w=%h", t, w, exp_t[0], exp_w[0]);
            else passes++;
            if (t == 6'd15 || t == 6'd16 || t == 6'd17) begin
               checks++;
               if ((t == 6'd15 && w !== 32'h00000018) || (t == 6'd16 && w !== 32'h61626380) || (t == 6'd17 && w !== 32'h000F0000))
                  $display("FAIL abc_const got t=%0d w=%h", t, w);
               else passes++;
            end
            if (exp_w.size() != 0) begin void'(exp_w.pop_front()); void'(exp_t.pop_front()); end
            nwords++;
         end
         if (done) done_at = cyc;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done_at < 0 || first_v < 0 || done_at - first_v != 64) $display("FAIL abc_done_latency got %0d exp 64", done_at - first_v);
      else passes++;
      checks++;
      if (nwords != 64) $display("FAIL abc_word_count got %0d exp 64", nwords);
      else passes++;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) $display("FAIL abc_idle_after_done got done=%b busy=%b valid=%b exp 0", done, busy, w_valid);
      else passes++;
   endtask

   task automatic test_zero();
      int cyc = 0, ndone = 0, nwords = 0, bad = 0;
      exp_w.delete(); exp_t.delete();
      block = 512'd0; start = 1'b1; advance = 1'b1; push_block(512'd0);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 80) begin
         if (w_valid) begin
            if (exp_w.size() == 0 || w !== exp_w[0] || w !== 32'd0 || t !== exp_t[0]) begin
               $display("FAIL zero_word got t=%0d w=%h exp t=%0d w=0", t, w, nwords);
               bad++;
            end
            if (exp_w.size() != 0) begin void'(exp_w.pop_front()); void'(exp_t.pop_front()); end
            nwords++;
         end
         if (done) ndone++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bad != 0 || nwords != 64) $display("FAIL zero_stream got %0d words %0d bad exp 64 words 0 bad", nwords, bad);
      else passes++;
      checks++;
      if (ndone != 1) $display("FAIL zero_done_pulses got %0d exp 1", ndone);
      else passes++;
   endtask

   task automatic test_stalls();
      int cyc = 0, nwords = 0, bad = 0, nstall = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_w = 32'd0;
      logic [5:0]  prev_t = 6'd0;
      exp_w.delete(); exp_t.delete();
      block = abc_blk; start = 1'b1; advance = 1'b0; push_block(abc_blk);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 600 && !done) begin
         if (w_valid) begin
            if (exp_w.size() == 0 || w !== exp_w[0] || t !== exp_t[0]) begin
               $display("FAIL stall_word got t=%0d w=%h", t, w);
               bad++;
            end
            if (prev_stall && (w !== prev_w || t !== prev_t)) begin
               $display("FAIL stall_hold got t=%0d w=%h exp t=%0d w=%h", t, w, prev_t, prev_w);
               bad++;
            end
            advance = ($urandom_range(0, 99) < 30);
            prev_stall = !advance; prev_w = w; prev_t = t;
            if (!advance) nstall++;
            if (advance && exp_w.size() != 0) begin
               void'(exp_w.pop_front()); void'(exp_t.pop_front());
               nwords++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bad != 0 || nwords != 64 || !done) $display("FAIL stall_stream got %0d words %0d bad done=%b exp 64/0/1", nwords, bad, done);
      else passes++;
      checks++;
      if (nstall == 0) $display("FAIL stall_coverage got 0 stalls exp >0");
      else passes++;
      advance = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      int cyc = 0, nwords = 0, bad = 0;
      exp_w.delete(); exp_t.delete();
      block = abc_blk; start = 1'b1; advance = 1'b1; push_block(abc_blk);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 100 && !done) begin
         start = 1'b0;
         if (w_valid) begin
            if (exp_w.size() == 0 || w !== exp_w[0] || t !== exp_t[0]) begin
               $display("FAIL ign_start_word got t=%0d w=%h", t, w);
               bad++;
            end
            if (t == 6'd20) begin
               start = 1'b1;
               block = {16{32'hDEADBEEF}};
            end
            if (exp_w.size() != 0) begin void'(exp_w.pop_front()); void'(exp_t.pop_front()); end
            nwords++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (bad != 0 || nwords != 64) $display("FAIL ign_start_stream got %0d words %0d bad exp 64/0", nwords, bad);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc = 0, saw_done = 0;
      exp_w.delete(); exp_t.delete();
      block = abc_blk; start = 1'b1; advance = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 100 && !(w_valid && t == 6'd40)) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!(w_valid && t == 6'd40)) $display("FAIL rst_mid_reach got t=%0d exp 40", t);
      else passes++;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++;
      if ({w_valid, busy, done} !== 3'b000 || w !== 32'd0 || t !== 6'd0)
         $display("FAIL rst_mid_outputs got flags=%b w=%h t=%0d exp 000/0/0", {w_valid, busy, done}, w, t);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done++;
      end
      checks++;
      if (saw_done != 0) $display("FAIL rst_mid_no_done got %0d pulses exp 0", saw_done);
      else passes++;
      block = abc_blk; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (!w_valid || w !== 32'h61626380 || t !== 6'd0) $display("FAIL rst_restart got valid=%b w=%h t=%0d exp 1/61626380/0", w_valid, w, t);
      else passes++;
      cyc = 0;
      while (cyc < 100 && !done) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done) $display("FAIL rst_restart_done got timeout exp done");
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [511:0] blk_b;
      int cyc = 0, nwords = 0, bad = 0;
      for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = $urandom();
      exp_w.delete(); exp_t.delete();
      block = abc_blk; start = 1'b1; advance = 1'b1; push_block(abc_blk);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 100 && !done) begin
         if (w_valid) begin
            if (exp_w.size() != 0) begin void'(exp_w.pop_front()); void'(exp_t.pop_front()); end
            nwords++;
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done || nwords != 64) $display("FAIL b2b_first got %0d words done=%b exp 64/1", nwords, done);
      else passes++;
      exp_w.delete(); exp_t.delete();
      block = blk_b; start = 1'b1; push_block(blk_b);
      cyc = 0;
      @(negedge clk);
      while (cyc < 4 && !w_valid) begin
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (!w_valid || w !== blk_b[511:480] || t !== 6'd0) $display("FAIL b2b_second_m0 got valid=%b w=%h t=%0d exp 1/%h/0", w_valid, w, t, blk_b[511:480]);
      else passes++;
      cyc = 0; nwords = 0;
      while (cyc < 100 && !done) begin
         if (w_valid) begin
            if (exp_w.size() == 0 || w !== exp_w[0] || t !== exp_t[0]) begin
               $display("FAIL b2b_word got t=%0d w=%h", t, w);
               bad++;
            end
            if (exp_w.size() != 0) begin void'(exp_w.pop_front()); void'(exp_t.pop_front()); end
            nwords++;
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bad != 0 || nwords != 64 || !done) $display("FAIL b2b_second_stream got %0d words %0d bad done=%b exp 64/0/1", nwords, bad, done);
      else passes++;
      @(negedge clk);
   endtask

   initial begin
      abc_blk = 512'd0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0]    = 32'h00000018;
      test_reset();
      test_abc();
      test_zero();
      test_stalls();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
